// File: rtl/mem_access_pkg.sv
// Shared widths, encodings, exception codes and request record for the
// memory-access stage.
package mem_access_pkg;

  localparam int ADDR_SIZE     = 32;
  localparam int REG_DATA_SIZE = 32;
  localparam int EX_WIDTH      = 3;

  // mem_op encodings (2'b11 is reserved and behaves like "none")
  localparam logic [1:0] MEM_OP_NONE  = 2'b00;
  localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
  localparam logic [1:0] MEM_OP_STORE = 2'b10;

  // mem_size encodings (2'b11 behaves like a word)
  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  // Exception codes raised by this stage
  localparam logic [EX_WIDTH:0] EXC_LOAD_MISALIGNED  = (EX_WIDTH+1)'(4);
  localparam logic [EX_WIDTH:0] EXC_LOAD_FAULT       = (EX_WIDTH+1)'(5);
  localparam logic [EX_WIDTH:0] EXC_STORE_MISALIGNED = (EX_WIDTH+1)'(6);
  localparam logic [EX_WIDTH:0] EXC_STORE_FAULT      = (EX_WIDTH+1)'(7);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Everything about an in-flight access, captured when it is accepted.
  typedef struct packed {
    logic                     is_store;
    logic [1:0]               size;
    logic                     is_unsigned;
    logic [4:0]               rd;
    logic [ADDR_SIZE-1:0]     addr;
    logic [REG_DATA_SIZE-1:0] store_data;
    logic [ADDR_SIZE-1:0]     pc;
  } mem_req_t;

  // Half accesses need addr[0]=0; word accesses need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (size)
      MEM_SIZE_BYTE: mis = 1'b0;
      MEM_SIZE_HALF: mis = addr_lo[0];
      default:       mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory bus between the memory-access stage and the data memory.
interface mem_access_if;
  import mem_access_pkg::*;

  logic [ADDR_SIZE-1:0]     dmem_addr;
  logic                     dmem_rd_enable;
  logic                     dmem_wr_enable;
  logic [REG_DATA_SIZE-1:0] dmem_wr_data;
  logic [3:0]               dmem_wr_strb;
  logic [REG_DATA_SIZE-1:0] dmem_rd_data;
  logic                     dmem_ready;

  modport master (
    output dmem_addr, dmem_rd_enable, dmem_wr_enable, dmem_wr_data, dmem_wr_strb,
    input  dmem_rd_data, dmem_ready
  );

  modport slave (
    input  dmem_addr, dmem_rd_enable, dmem_wr_enable, dmem_wr_data, dmem_wr_strb,
    output dmem_rd_data, dmem_ready
  );

endinterface

// File: rtl/mem_access_lsu_align.sv
// Byte-lane steering: load extraction/extension and store replication/strobes.
module lsu_align
  import mem_access_pkg::*;
(
  input  logic [1:0]               addr_lo,
  input  logic [1:0]               size,
  input  logic                     is_unsigned,
  input  logic [REG_DATA_SIZE-1:0] rd_word,
  input  logic [REG_DATA_SIZE-1:0] st_raw,
  output logic [REG_DATA_SIZE-1:0] ld_data,
  output logic [REG_DATA_SIZE-1:0] st_data,
  output logic [3:0]               st_strb
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Pick the addressed byte/half out of the returned word and extend it.
  always_comb begin
    case (addr_lo)
      2'd0:    ld_byte = rd_word[7:0];
      2'd1:    ld_byte = rd_word[15:8];
      2'd2:    ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    ld_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    case (size)
      MEM_SIZE_BYTE: ld_data = {{24{~is_unsigned & ld_byte[7]}}, ld_byte};
      MEM_SIZE_HALF: ld_data = {{16{~is_unsigned & ld_half[15]}}, ld_half};
      default:       ld_data = rd_word;
    endcase
  end

  // Replicate narrow store data across the word; strobes pick the lanes.
  always_comb begin
    case (size)
      MEM_SIZE_BYTE: begin
        st_data = {4{st_raw[7:0]}};
        st_strb = 4'b0001 << addr_lo;
      end
      MEM_SIZE_HALF: begin
        st_data = {2{st_raw[15:0]}};
        st_strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = st_raw;
        st_strb = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: single outstanding load/store with a timeout,
// ALU-result passthrough to writeback, and exception reporting.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pipeline_in_valid,
  input  logic [ADDR_SIZE-1:0]     PC_in,
  input  logic [EX_WIDTH:0]        exception_in,
  input  logic                     exception_in_valid,
  input  logic [4:0]               rd_addr_in,
  input  logic [REG_DATA_SIZE-1:0] result_in,
  input  logic [1:0]               mem_op_in,
  input  logic [1:0]               mem_size_in,
  input  logic                     mem_unsigned_in,
  input  logic [REG_DATA_SIZE-1:0] store_data_in,
  output logic                     stall_out,
  mem_access_if.master             dmem,
  output logic                     rf_wr_enable,
  output logic [4:0]               rf_wr_addr,
  output logic [REG_DATA_SIZE-1:0] rf_wr_data,
  output logic [EX_WIDTH:0]        exception_out,
  output logic                     exception_out_valid,
  output logic [ADDR_SIZE-1:0]     PC_out
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_e     state, state_nxt;
  logic [CNT_W-1:0] cnt;
  mem_req_t   req_q;

  logic accept, is_mem, is_store, misal, start, timeout;
  logic [REG_DATA_SIZE-1:0] ld_data, st_data;
  logic [3:0] st_strb;

  // Stall is only ever raised in WAIT, so IDLE is the acceptance window.
  assign accept   = pipeline_in_valid && (state == ST_IDLE);
  assign is_store = (mem_op_in == MEM_OP_STORE);
  assign is_mem   = (mem_op_in == MEM_OP_LOAD) || is_store;
  assign misal    = is_misaligned(mem_size_in, result_in[1:0]);
  assign start    = accept && !exception_in_valid && is_mem && !misal;
  assign timeout  = (cnt == CNT_W'(MEM_TIMEOUT - 1));

  lsu_align u_align (
    .addr_lo     (req_q.addr[1:0]),
    .size        (req_q.size),
    .is_unsigned (req_q.is_unsigned),
    .rd_word     (dmem.dmem_rd_data),
    .st_raw      (req_q.store_data),
    .ld_data     (ld_data),
    .st_data     (st_data),
    .st_strb     (st_strb)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state and bus drive; the request is live exactly while in WAIT.
  always_comb begin
    state_nxt           = state;
    stall_out           = 1'b0;
    dmem.dmem_addr      = '0;
    dmem.dmem_rd_enable = 1'b0;
    dmem.dmem_wr_enable = 1'b0;
    dmem.dmem_wr_data   = '0;
    dmem.dmem_wr_strb   = '0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        stall_out           = 1'b1;
        dmem.dmem_addr      = {req_q.addr[ADDR_SIZE-1:2], 2'b00};
        dmem.dmem_rd_enable = !req_q.is_store;
        dmem.dmem_wr_enable = req_q.is_store;
        if (req_q.is_store) begin
          dmem.dmem_wr_data = st_data;
          dmem.dmem_wr_strb = st_strb;
        end
        if (dmem.dmem_ready || timeout) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // WAIT-cycle counter, restarted for every new access.
  always_ff @(posedge clk) begin
    if (reset || start)        cnt <= '0;
    else if (state == ST_WAIT) cnt <= cnt + 1'b1;
  end

  // Capture the access at acceptance; upstream may change while we wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q <= '0;
    end else if (start) begin
      req_q.is_store    <= is_store;
      req_q.size        <= mem_size_in;
      req_q.is_unsigned <= mem_unsigned_in;
      req_q.rd          <= rd_addr_in;
      req_q.addr        <= result_in;
      req_q.store_data  <= store_data_in;
      req_q.pc          <= PC_in;
    end
  end

  // Writeback / trap reporting: single-cycle pulses, data held between them.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_wr_enable        <= 1'b0;
      rf_wr_addr          <= '0;
      rf_wr_data          <= '0;
      exception_out       <= '0;
      exception_out_valid <= 1'b0;
      PC_out              <= '0;
    end else begin
      rf_wr_enable        <= 1'b0;
      exception_out_valid <= 1'b0;
      if (accept) begin
        if (exception_in_valid) begin
          exception_out       <= exception_in;
          exception_out_valid <= 1'b1;
          PC_out              <= PC_in;
        end else if (is_mem && misal) begin
          exception_out       <= is_store ? EXC_STORE_MISALIGNED : EXC_LOAD_MISALIGNED;
          exception_out_valid <= 1'b1;
          PC_out              <= PC_in;
        end else if (!is_mem) begin
          rf_wr_enable <= (rd_addr_in != 5'd0);
          rf_wr_addr   <= rd_addr_in;
          rf_wr_data   <= result_in;
          PC_out       <= PC_in;
        end
      end else if (state == ST_WAIT) begin
        // ready beats a timeout landing on the same edge
        if (dmem.dmem_ready) begin
          if (!req_q.is_store) begin
            rf_wr_enable <= (req_q.rd != 5'd0);
            rf_wr_addr   <= req_q.rd;
            rf_wr_data   <= ld_data;
            PC_out       <= req_q.pc;
          end
        end else if (timeout) begin
          exception_out       <= req_q.is_store ? EXC_STORE_FAULT : EXC_LOAD_FAULT;
          exception_out_valid <= 1'b1;
          PC_out              <= req_q.pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: single-cycle vector table plus directed memory sequences,
// with a scoreboard of expected writeback/exception reports.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int TO = 64;

  logic        clk, reset;
  logic        pipeline_in_valid;
  logic [31:0] PC_in;
  logic [3:0]  exception_in;
  logic        exception_in_valid;
  logic [4:0]  rd_addr_in;
  logic [31:0] result_in;
  logic [1:0]  mem_op_in, mem_size_in;
  logic        mem_unsigned_in;
  logic [31:0] store_data_in;
  logic        stall_out;
  logic        rf_wr_enable;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [3:0]  exception_out;
  logic        exception_out_valid;
  logic [31:0] PC_out;

  mem_access_if bus();

  mem_access #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .pipeline_in_valid(pipeline_in_valid), .PC_in(PC_in),
    .exception_in(exception_in), .exception_in_valid(exception_in_valid),
    .rd_addr_in(rd_addr_in), .result_in(result_in),
    .mem_op_in(mem_op_in), .mem_size_in(mem_size_in),
    .mem_unsigned_in(mem_unsigned_in), .store_data_in(store_data_in),
    .stall_out(stall_out), .dmem(bus),
    .rf_wr_enable(rf_wr_enable), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .exception_out(exception_out), .exception_out_valid(exception_out_valid),
    .PC_out(PC_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_exc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [3:0]  exc;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic        valid;
    logic [3:0]  exc_in;
    logic        exc_v;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [1:0]  op;
    logic [1:0]  size;
    logic [1:0]  kind;      // 0 nothing, 1 rf write, 2 exception
    logic [31:0] exp_data;
    logic [3:0]  exp_exc;
  } vec_t;

  exp_t        sbq[$];
  vec_t        tbl[10];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Advance one clock and compare any reported result against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (rf_wr_enable || exception_out_valid) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_output: wr=%b addr=%0d data=%h exc_v=%b exc=%0d pc=%h, nothing expected",
                 rf_wr_enable, rf_wr_addr, rf_wr_data, exception_out_valid, exception_out, PC_out);
      end else begin
        e = sbq.pop_front();
        chk("out_kind", 32'({rf_wr_enable, exception_out_valid}), e.is_exc ? 32'd1 : 32'd2);
        if (e.is_exc) chk("exc_code", 32'(exception_out), 32'(e.exc));
        else begin
          chk("rf_addr", 32'(rf_wr_addr), 32'(e.rd));
          chk("rf_data", rf_wr_data, e.data);
        end
        chk("pc_out", PC_out, e.pc);
      end
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] exc, input logic exc_v,
                       input logic [4:0] rd, input logic [31:0] res, input logic [1:0] op,
                       input logic [1:0] size, input logic uns, input logic [31:0] sd);
    pc_ctr             = pc_ctr + 32'd4;
    pipeline_in_valid  = v;
    PC_in              = pc_ctr;
    exception_in       = exc;
    exception_in_valid = exc_v;
    rd_addr_in         = rd;
    result_in          = res;
    mem_op_in          = op;
    mem_size_in        = size;
    mem_unsigned_in    = uns;
    store_data_in      = sd;
  endtask

  // One load/store: checks the bus each WAIT cycle, answers with ready on
  // WAIT cycle 'lat' (never if lat > TO). An ALU op held upstream during the
  // wait must only be accepted once the access ends.
  task automatic mem_seq(input string nm, input logic [1:0] op, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] rd, input logic [31:0] rword, input int lat,
                         input logic [3:0] exp_strb, input logic [31:0] exp_wd,
                         input logic [31:0] exp_ld);
    logic ld;
    ld = (op == MEM_OP_LOAD);
    drive(1'b1, 4'h0, 1'b0, rd, addr, op, size, uns, sd);
    if (lat > TO) sbq.push_back('{1'b1, 5'd0, 32'h0, ld ? 4'd5 : 4'd7, pc_ctr});
    else if (ld && rd != 5'd0) sbq.push_back('{1'b0, rd, exp_ld, 4'h0, pc_ctr});
    tick();
    drive(1'b1, 4'h0, 1'b0, 5'd9, 32'h0000_9999, MEM_OP_NONE, MEM_SIZE_WORD, 1'b0, 32'h0);
    sbq.push_back('{1'b0, 5'd9, 32'h0000_9999, 4'h0, pc_ctr});
    bus.dmem_rd_data = rword;
    for (int c = 1; c <= TO; c++) begin
      chk({nm, "_stall"}, 32'(stall_out), 32'd1);
      chk({nm, "_rd_en"}, 32'(bus.dmem_rd_enable), 32'(ld));
      chk({nm, "_wr_en"}, 32'(bus.dmem_wr_enable), 32'(!ld));
      chk({nm, "_addr"}, bus.dmem_addr, {addr[31:2], 2'b00});
      if (!ld) begin
        chk({nm, "_strb"}, 32'(bus.dmem_wr_strb), 32'(exp_strb));
        chk({nm, "_wdata"}, bus.dmem_wr_data, exp_wd);
      end
      bus.dmem_ready = (c == lat);
      tick();
      bus.dmem_ready = 1'b0;
      if (c == lat) break;
    end
    chk({nm, "_stall_done"}, 32'(stall_out), 32'd0);
    chk({nm, "_rd_en_done"}, 32'(bus.dmem_rd_enable), 32'd0);
    chk({nm, "_wr_en_done"}, 32'(bus.dmem_wr_enable), 32'd0);
    tick();
    pipeline_in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.dmem_ready   = 1'b0;
    bus.dmem_rd_data = 32'h0;
    drive(1'b0, 4'h0, 1'b0, 5'd0, 32'h0, MEM_OP_NONE, MEM_SIZE_WORD, 1'b0, 32'h0);
    tick();
    tick();
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_rd_en", 32'(bus.dmem_rd_enable), 32'd0);
    chk("rst_wr_en", 32'(bus.dmem_wr_enable), 32'd0);
    chk("rst_rf_en", 32'(rf_wr_enable), 32'd0);
    chk("rst_exc_v", 32'(exception_out_valid), 32'd0);
    chk("rst_pc", PC_out, 32'd0);
    reset = 1'b0;

    //            valid exc  excv  rd     result          op     size   kind expdata         expexc
    tbl[0] = '{1'b1, 4'h0, 1'b0, 5'd5,  32'h0000_1234, 2'b00, 2'b10, 2'd1, 32'h0000_1234, 4'h0};
    tbl[1] = '{1'b1, 4'h0, 1'b0, 5'd0,  32'h0000_1234, 2'b00, 2'b10, 2'd0, 32'h0,         4'h0};
    tbl[2] = '{1'b1, 4'h0, 1'b0, 5'd7,  32'hDEAD_BEEF, 2'b11, 2'b10, 2'd1, 32'hDEAD_BEEF, 4'h0};
    tbl[3] = '{1'b1, 4'h0, 1'b0, 5'd3,  32'h0000_0102, 2'b01, 2'b10, 2'd2, 32'h0,         4'd4};
    tbl[4] = '{1'b1, 4'h0, 1'b0, 5'd3,  32'h0000_0101, 2'b01, 2'b01, 2'd2, 32'h0,         4'd4};
    tbl[5] = '{1'b1, 4'h0, 1'b0, 5'd0,  32'h0000_0103, 2'b10, 2'b10, 2'd2, 32'h0,         4'd6};
    tbl[6] = '{1'b1, 4'h0, 1'b0, 5'd0,  32'h0000_0201, 2'b10, 2'b01, 2'd2, 32'h0,         4'd6};
    tbl[7] = '{1'b1, 4'd2, 1'b1, 5'd4,  32'h0000_0100, 2'b01, 2'b10, 2'd2, 32'h0,         4'd2};
    tbl[8] = '{1'b0, 4'h0, 1'b0, 5'd6,  32'h0000_5555, 2'b00, 2'b10, 2'd0, 32'h0,         4'h0};
    tbl[9] = '{1'b1, 4'd3, 1'b1, 5'd8,  32'h0000_0103, 2'b01, 2'b00, 2'd2, 32'h0,         4'd3};

    foreach (tbl[i]) begin
      drive(tbl[i].valid, tbl[i].exc_in, tbl[i].exc_v, tbl[i].rd, tbl[i].res,
            tbl[i].op, tbl[i].size, 1'b0, 32'hFFFF_FFFF);
      if (tbl[i].kind == 2'd1) sbq.push_back('{1'b0, tbl[i].rd, tbl[i].exp_data, 4'h0, pc_ctr});
      if (tbl[i].kind == 2'd2) sbq.push_back('{1'b1, 5'd0, 32'h0, tbl[i].exp_exc, pc_ctr});
      tick();
      chk("vec_stall", 32'(stall_out), 32'd0);
      chk("vec_rd_en", 32'(bus.dmem_rd_enable), 32'd0);
      chk("vec_wr_en", 32'(bus.dmem_wr_enable), 32'd0);
    end
    pipeline_in_valid = 1'b0;
    tick();

    //      name     op            size           uns   addr          sdata         rd     rword         lat    strb     wdata         load result
    mem_seq("lb",   MEM_OP_LOAD,  MEM_SIZE_BYTE, 1'b0, 32'h0000_0103, 32'h0,        5'd10, 32'h80FF_0000, 3,    4'b0000, 32'h0,        32'hFFFF_FF80);
    mem_seq("lbu",  MEM_OP_LOAD,  MEM_SIZE_BYTE, 1'b1, 32'h0000_0103, 32'h0,        5'd10, 32'h80FF_0000, 3,    4'b0000, 32'h0,        32'h0000_0080);
    mem_seq("sh",   MEM_OP_STORE, MEM_SIZE_HALF, 1'b0, 32'h0000_0202, 32'h1357_ABCD, 5'd0, 32'h0,         1,    4'b1100, 32'hABCD_ABCD, 32'h0);
    mem_seq("sb",   MEM_OP_STORE, MEM_SIZE_BYTE, 1'b0, 32'h0000_0001, 32'h0000_005A, 5'd0, 32'h0,         2,    4'b0010, 32'h5A5A_5A5A, 32'h0);
    mem_seq("lh",   MEM_OP_LOAD,  MEM_SIZE_HALF, 1'b0, 32'h0000_0102, 32'h0,        5'd12, 32'h8001_7FFF, 2,    4'b0000, 32'h0,        32'hFFFF_8001);
    mem_seq("lhu",  MEM_OP_LOAD,  MEM_SIZE_HALF, 1'b1, 32'h0000_0100, 32'h0,        5'd13, 32'h8001_F00F, 1,    4'b0000, 32'h0,        32'h0000_F00F);
    mem_seq("lb_x0",MEM_OP_LOAD,  MEM_SIZE_BYTE, 1'b0, 32'h0000_0004, 32'h0,        5'd0,  32'h0000_00FF, 1,    4'b0000, 32'h0,        32'h0);
    mem_seq("lw_edge",MEM_OP_LOAD,MEM_SIZE_WORD, 1'b0, 32'h0000_0300, 32'h0,        5'd11, 32'hCAFE_F00D, TO,   4'b0000, 32'h0,        32'hCAFE_F00D);
    mem_seq("sw_to",MEM_OP_STORE, MEM_SIZE_WORD, 1'b0, 32'h0000_0400, 32'h1122_3344, 5'd0, 32'h0,         TO+10,4'b1111, 32'h1122_3344, 32'h0);
    mem_seq("lw_to",MEM_OP_LOAD,  MEM_SIZE_WORD, 1'b0, 32'h0000_0500, 32'h0,        5'd14, 32'h0,         TO+10,4'b0000, 32'h0,        32'h0);

    // Reset landing in the second WAIT cycle of a load: everything clears,
    // and a late ready must not produce a writeback.
    drive(1'b1, 4'h0, 1'b0, 5'd15, 32'h0000_0600, MEM_OP_LOAD, MEM_SIZE_WORD, 1'b0, 32'h0);
    tick();
    pipeline_in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("rstw_stall", 32'(stall_out), 32'd0);
    chk("rstw_rd_en", 32'(bus.dmem_rd_enable), 32'd0);
    chk("rstw_wr_en", 32'(bus.dmem_wr_enable), 32'd0);
    chk("rstw_addr", bus.dmem_addr, 32'd0);
    chk("rstw_strb", 32'(bus.dmem_wr_strb), 32'd0);
    chk("rstw_wdata", bus.dmem_wr_data, 32'd0);
    chk("rstw_rf_en", 32'(rf_wr_enable), 32'd0);
    chk("rstw_rf_addr", 32'(rf_wr_addr), 32'd0);
    chk("rstw_rf_data", rf_wr_data, 32'd0);
    chk("rstw_exc_v", 32'(exception_out_valid), 32'd0);
    chk("rstw_exc", 32'(exception_out), 32'd0);
    chk("rstw_pc", PC_out, 32'd0);
    reset = 1'b0;
    bus.dmem_rd_data = 32'h7777_7777;
    bus.dmem_ready   = 1'b1;
    tick();
    bus.dmem_ready = 1'b0;
    tick();
    chk("rstw_after_stall", 32'(stall_out), 32'd0);
    chk("rstw_after_rf_en", 32'(rf_wr_enable), 32'd0);

    chk("scoreboard_left", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
